// File: rtl/line_window_ctrl.sv
// Frame sequencer for the (2R+1)x(2R+1) line-window buffer: gates the pixel
// stream into the buffer, tracks raster position and flags interior windows.
module line_window_ctrl #(
    parameter int IMAGE_WIDTH  = 508,
    parameter int IMAGE_HEIGHT = 508,
    parameter int R            = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_pixel,
    output logic        in_ready,
    input  logic        out_ready,
    output logic        buf_write,
    output logic [7:0]  buf_pixel,
    output logic        win_valid,
    output logic [10:0] win_row,
    output logic [10:0] win_col,
    output logic        busy,
    output logic        frame_done,
    output logic        err_start
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_DONE} state_t;

    localparam logic [10:0] C_EDGE     = 11'(2 * R);
    localparam logic [10:0] C_RAD      = 11'(R);
    localparam logic [10:0] C_LAST_COL = 11'(IMAGE_WIDTH - 1);
    localparam logic [10:0] C_LAST_ROW = 11'(IMAGE_HEIGHT - 1);

    state_t      r_state, w_next;
    logic [10:0] r_row, r_col;
    logic        w_busy, w_xfer, w_last_col, w_interior;

    assign w_busy     = (r_state == S_FILL) || (r_state == S_STREAM);
    assign in_ready   = w_busy & out_ready;
    assign w_xfer     = in_valid & in_ready;
    assign buf_write  = w_xfer;
    assign buf_pixel  = in_pixel;
    assign busy       = w_busy;
    assign frame_done = (r_state == S_DONE);
    assign w_last_col = (r_col == C_LAST_COL);
    // Rows/cols below 2R hold stale or row-straddling data, so they never qualify.
    assign w_interior = (r_row >= C_EDGE) && (r_col >= C_EDGE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_FILL;
            S_FILL:   if (w_xfer && r_row == C_EDGE && r_col == C_EDGE) w_next = S_STREAM;
            S_STREAM: if (w_xfer && r_row == C_LAST_ROW && w_last_col) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_xfer) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= r_row + 11'd1;
            end else begin
                r_col <= r_col + 11'd1;
            end
        end
    end

    // A start outside IDLE sets the flag; a start honoured in IDLE clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        err_start <= 1'b0;
        else if (start) err_start <= (r_state != S_IDLE);
    end

    // Registered one cycle after the transfer to line up with the buffer write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            win_valid <= w_xfer & w_interior;
            if (w_xfer && w_interior) begin
                win_row <= r_row - C_RAD;
                win_col <= r_col - C_RAD;
            end
        end
    end

endmodule

// File: tb/tb_line_window_ctrl.sv
// Directed bench for line_window_ctrl at W=8, H=6, R=1 (24 windows per frame).
module tb_line_window_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b1;
    logic [7:0]  in_pixel = 8'd0;
    logic        out_ready = 1'b1;
    logic        in_ready, buf_write, win_valid, busy, frame_done, err_start;
    logic [7:0]  buf_pixel;
    logic [10:0] win_row, win_col;

    int n_run = 0;
    int n_fail = 0;

    line_window_ctrl #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(6), .R(1)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_pixel(in_pixel),
        .in_ready(in_ready), .out_ready(out_ready), .buf_write(buf_write),
        .buf_pixel(buf_pixel), .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
        .busy(busy), .frame_done(frame_done), .err_start(err_start)
    );

    always #5 clk = ~clk;

    // Monitor: independent raster model of which transfers must raise win_valid.
    logic        mon_clr = 1'b0;
    int          cyc = 0, xfer_cnt = 0, px18_cyc = -1, first_win_cyc = -1;
    int          fd_cnt = 0, fd_last_ok = 0, wv_err = 0;
    logic        exp_wv = 1'b0;
    logic [10:0] last_r = '0, last_c = '0;
    logic [21:0] win_q[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            xfer_cnt <= 0;
            exp_wv   <= 1'b0;
            last_r   <= '0;
            last_c   <= '0;
        end else if (mon_clr) begin
            xfer_cnt      <= 0;
            exp_wv        <= 1'b0;
            px18_cyc      <= -1;
            first_win_cyc <= -1;
            fd_cnt        <= 0;
            fd_last_ok    <= 0;
            wv_err        <= 0;
            win_q.delete();
        end else begin
            if (win_valid !== exp_wv) wv_err <= wv_err + 1;
            if (win_valid) begin
                win_q.push_back({win_row, win_col});
                last_r <= win_row;
                last_c <= win_col;
                if (first_win_cyc < 0) first_win_cyc <= cyc;
            end else if (win_row !== last_r || win_col !== last_c) begin
                wv_err <= wv_err + 1;
            end
            if (frame_done) begin
                fd_cnt <= fd_cnt + 1;
                if (win_valid && win_row == 11'd4 && win_col == 11'd6) fd_last_ok <= fd_last_ok + 1;
            end
            if (buf_write) begin
                exp_wv <= ((xfer_cnt / 8) >= 2) && ((xfer_cnt % 8) >= 2);
                if (xfer_cnt == 18) px18_cyc <= cyc;
                xfer_cnt <= xfer_cnt + 1;
                if (buf_pixel !== in_pixel) wv_err <= wv_err + 1;
            end else begin
                exp_wv <= 1'b0;
            end
        end
    end

    // Mismatches between the logged windows and the raster-order interior centres.
    function automatic int seq_errs();
        int e = 0;
        logic [21:0] exp;
        if (win_q.size() != 24) return 99;
        for (int i = 0; i < 24; i++) begin
            exp = {11'(1 + i / 6), 11'(1 + i % 6)};
            if (win_q[i] !== exp) e++;
        end
        return e;
    endfunction

    task automatic do_start();
        start = 1'b1;
        mon_clr = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mon_clr = 1'b0;
    endtask

    task automatic feed(input int n, input int idle_pct);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 2000) begin
            in_valid  = ($urandom_range(0, 99) >= idle_pct);
            in_pixel  = 8'(sent * 7 + 3);
            out_ready = 1'b1;
            @(negedge clk);
            if (buf_write) sent++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        n_run++;
        if (sent != n) begin
            $display("FAIL feed_timeout: accepted %0d, required %0d", sent, n);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_run += 6;
        if (busy !== 1'b0)       begin $display("FAIL rst_busy: got %b want 0", busy); n_fail++; end
        if (in_ready !== 1'b0)   begin $display("FAIL rst_in_ready: got %b want 0", in_ready); n_fail++; end
        if (win_valid !== 1'b0)  begin $display("FAIL rst_win_valid: got %b want 0", win_valid); n_fail++; end
        if (frame_done !== 1'b0) begin $display("FAIL rst_frame_done: got %b want 0", frame_done); n_fail++; end
        if (err_start !== 1'b0)  begin $display("FAIL rst_err_start: got %b want 0", err_start); n_fail++; end
        if ({win_row, win_col} !== 22'd0) begin $display("FAIL rst_win_coord: got %0d,%0d want 0,0", win_row, win_col); n_fail++; end
        rst = 1'b0;
        @(posedge clk); #1;
        n_run++;
        if (buf_write !== 1'b0) begin $display("FAIL idle_buf_write: got %b want 0", buf_write); n_fail++; end
        in_valid = 1'b0;
    endtask

    task automatic test_continuous();
        do_start();
        n_run++;
        if (busy !== 1'b1) begin $display("FAIL cont_busy: got %b want 1", busy); n_fail++; end
        feed(48, 0);
        repeat (3) @(posedge clk);
        #1;
        n_run += 8;
        if (win_q.size() != 24)  begin $display("FAIL cont_count: got %0d want 24", win_q.size()); n_fail++; end
        if (seq_errs() != 0)     begin $display("FAIL cont_seq: got %0d errors want 0", seq_errs()); n_fail++; end
        if (first_win_cyc - px18_cyc != 1) begin $display("FAIL cont_first_lat: got %0d want 1", first_win_cyc - px18_cyc); n_fail++; end
        if (fd_cnt != 1)         begin $display("FAIL cont_fd_cnt: got %0d want 1", fd_cnt); n_fail++; end
        if (fd_last_ok != 1)     begin $display("FAIL cont_last_win_fd: got %0d want 1", fd_last_ok); n_fail++; end
        if (wv_err != 0)         begin $display("FAIL cont_boundary: got %0d errors want 0", wv_err); n_fail++; end
        if (xfer_cnt != 48)      begin $display("FAIL cont_writes: got %0d want 48", xfer_cnt); n_fail++; end
        if (busy !== 1'b0)       begin $display("FAIL cont_busy_end: got %b want 0", busy); n_fail++; end
    endtask

    task automatic test_gaps();
        do_start();
        feed(48, 30);
        repeat (3) @(posedge clk);
        #1;
        n_run += 4;
        if (seq_errs() != 0) begin $display("FAIL gap_seq: got %0d errors want 0", seq_errs()); n_fail++; end
        if (xfer_cnt != 48)  begin $display("FAIL gap_writes: got %0d want 48", xfer_cnt); n_fail++; end
        if (wv_err != 0)     begin $display("FAIL gap_boundary: got %0d errors want 0", wv_err); n_fail++; end
        if (fd_cnt != 1)     begin $display("FAIL gap_fd_cnt: got %0d want 1", fd_cnt); n_fail++; end
    endtask

    task automatic test_backpressure();
        do_start();
        feed(27, 0);
        in_valid = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_run += 2;
            if (in_ready !== 1'b0)  begin $display("FAIL bp_in_ready: cycle %0d got %b want 0", k, in_ready); n_fail++; end
            if (buf_write !== 1'b0) begin $display("FAIL bp_buf_write: cycle %0d got %b want 0", k, buf_write); n_fail++; end
            if (k > 0) begin
                n_run++;
                if (win_valid !== 1'b0) begin $display("FAIL bp_win_valid: cycle %0d got %b want 0", k, win_valid); n_fail++; end
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        feed(21, 0);
        repeat (3) @(posedge clk);
        #1;
        n_run += 3;
        if (seq_errs() != 0) begin $display("FAIL bp_seq: got %0d errors want 0", seq_errs()); n_fail++; end
        if (wv_err != 0)     begin $display("FAIL bp_boundary: got %0d errors want 0", wv_err); n_fail++; end
        if (fd_cnt != 1)     begin $display("FAIL bp_fd_cnt: got %0d want 1", fd_cnt); n_fail++; end
    endtask

    task automatic test_reset_midframe();
        do_start();
        feed(30, 0);
        rst = 1'b1;
        #1;
        n_run += 4;
        if (busy !== 1'b0)      begin $display("FAIL mrst_busy: got %b want 0", busy); n_fail++; end
        if (in_ready !== 1'b0)  begin $display("FAIL mrst_in_ready: got %b want 0", in_ready); n_fail++; end
        if (win_valid !== 1'b0) begin $display("FAIL mrst_win_valid: got %b want 0", win_valid); n_fail++; end
        if ({win_row, win_col} !== 22'd0) begin $display("FAIL mrst_win_coord: got %0d,%0d want 0,0", win_row, win_col); n_fail++; end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_start();
        feed(48, 0);
        repeat (3) @(posedge clk);
        #1;
        n_run += 3;
        if (seq_errs() != 0) begin $display("FAIL mrst_seq: got %0d errors want 0", seq_errs()); n_fail++; end
        if (first_win_cyc - px18_cyc != 1) begin $display("FAIL mrst_first_lat: got %0d want 1", first_win_cyc - px18_cyc); n_fail++; end
        if (wv_err != 0)     begin $display("FAIL mrst_boundary: got %0d errors want 0", wv_err); n_fail++; end
    endtask

    task automatic test_err_start();
        do_start();
        feed(20, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_run += 2;
        if (err_start !== 1'b1) begin $display("FAIL err_set: got %b want 1", err_start); n_fail++; end
        if (busy !== 1'b1)      begin $display("FAIL err_busy: got %b want 1", busy); n_fail++; end
        feed(28, 0);
        repeat (3) @(posedge clk);
        #1;
        n_run += 3;
        if (err_start !== 1'b1) begin $display("FAIL err_sticky: got %b want 1", err_start); n_fail++; end
        if (seq_errs() != 0)    begin $display("FAIL err_seq: got %0d errors want 0", seq_errs()); n_fail++; end
        if (fd_cnt != 1)        begin $display("FAIL err_fd_cnt: got %0d want 1", fd_cnt); n_fail++; end
        do_start();
        n_run++;
        if (err_start !== 1'b0) begin $display("FAIL err_clear: got %b want 0", err_start); n_fail++; end
        // start coinciding with the final transfer must be refused
        feed(47, 0);
        in_valid = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        start = 1'b0;
        n_run++;
        if (err_start !== 1'b1) begin $display("FAIL err_last_xfer: got %b want 1", err_start); n_fail++; end
        repeat (3) @(posedge clk);
        #1;
        n_run += 3;
        if (busy !== 1'b0)      begin $display("FAIL err_no_restart: got %b want 0", busy); n_fail++; end
        if (fd_cnt != 1)        begin $display("FAIL err_last_fd: got %0d want 1", fd_cnt); n_fail++; end
        if (win_q.size() != 24) begin $display("FAIL err_last_count: got %0d want 24", win_q.size()); n_fail++; end
    endtask

    task automatic test_back_to_back();
        do_start();
        feed(48, 0);
        @(posedge clk); #1;
        do_start();
        n_run += 2;
        if (busy !== 1'b1)      begin $display("FAIL b2b_busy: got %b want 1", busy); n_fail++; end
        if (err_start !== 1'b0) begin $display("FAIL b2b_err: got %b want 0", err_start); n_fail++; end
        feed(48, 0);
        repeat (3) @(posedge clk);
        #1;
        n_run += 3;
        if (seq_errs() != 0) begin $display("FAIL b2b_seq: got %0d errors want 0", seq_errs()); n_fail++; end
        if (fd_cnt != 1)     begin $display("FAIL b2b_fd_cnt: got %0d want 1", fd_cnt); n_fail++; end
        if (wv_err != 0)     begin $display("FAIL b2b_boundary: got %0d errors want 0", wv_err); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_backpressure();
        test_reset_midframe();
        test_err_start();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/line_window_ctrl.md
Name: line_window_ctrl

Overview:
- Frame sequencer for the 3x3 (2R+1 square) line-window buffer between the Gaussian and Sobel stages.
- Accepts a raster pixel stream with a valid/ready handshake and drives the buffer's write strobe and pixel input.
- Tracks row and column position and flags the cycles where the buffer's window holds a fully interior neighbourhood, tagged with its centre coordinates.
- Pulses frame completion; applies back-pressure from the Sobel stage.

Parameters:
- IMAGE_WIDTH, 508, pixels per row (≥ 2R+2).
- IMAGE_HEIGHT, 508, rows per frame (≥ 2R+2).
- R, 1, window radius; window is (2R+1)x(2R+1).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a frame; honoured only in IDLE
- in_valid  input  1  upstream pixel valid
- in_pixel  input  8  upstream pixel, raster order
- in_ready  output  1  controller accepts in_pixel this cycle
- out_ready  input  1  Sobel stage can take a window next cycle
- buf_write  output  1  write strobe to line buffer (combinational: in_valid & in_ready)
- buf_pixel  output  8  pixel to line buffer (pass-through of in_pixel)
- win_valid  output  1  buffer window is a valid interior neighbourhood this cycle
- win_row  output  11  centre row of the valid window
- win_col  output  11  centre column of the valid window
- busy  output  1  high in FILL/STREAM
- frame_done  output  1  one-cycle pulse at end of frame
- err_start  output  1  sticky; start seen while not IDLE, cleared by rst or next accepted start

Behaviour:
- Reset (async, any state, including mid-frame): state=IDLE; row=col=0; win_valid=0, win_row=win_col=0, frame_done=0, busy=0, err_start=0. The buffer contents are not cleared; stale data is masked by the row/column gating below.
- States and transitions:
  - IDLE: start=1 → FILL, with row=col=0 and err_start cleared.
  - FILL: first R*2*IMAGE_WIDTH+2R+1 accepted pixels. Transitions to STREAM on the accepted pixel at (row=2R, col=2R).
  - STREAM: runs until the accepted pixel at (IMAGE_HEIGHT-1, IMAGE_WIDTH-1), then → DONE.
  - DONE: one cycle; frame_done=1; then → IDLE.
- Handshake:
  - in_ready = busy & out_ready.
  - A transfer occurs when in_valid & in_ready, which is exactly buf_write.
  - No transfer leaves all counters and the buffer unchanged.
- Counters:
  - On each transfer, col increments; at col=IMAGE_WIDTH-1, col wraps to 0 and row increments.
  - Counters are 11-bit unsigned; no wrap beyond IMAGE_HEIGHT-1, because the state leaves STREAM first.
- Window flag (registered, one cycle after the transfer, matching the buffer's 1-cycle write latency):
  - win_valid=1 iff the transfer's pixel had row ≥ 2R and col ≥ 2R.
  - win_row = row−R and win_col = col−R of that pixel; both hold their last value when win_valid=0.
  - Row-edge positions (col < 2R) never raise win_valid, even though the buffer shifts.
  - Valid windows per frame = (IMAGE_WIDTH−2R)*(IMAGE_HEIGHT−2R).
- Last pixel: its window (row=H−1−R, col=W−1−R) appears with win_valid in the same cycle frame_done pulses.
- start while FILL/STREAM/DONE is ignored and sets err_start.
- start and the last transfer in the same cycle: start is ignored and err_start is set.
- A new frame may start the cycle after DONE (IDLE then start).

Test Plan (W=8, H=6, R=1 unless stated):
- Continuous stream of 48 pixels, in_valid=1, out_ready=1 → exactly 24 win_valid cycles.
  - First valid window at centre (1,1), one cycle after pixel 18 (row 2, col 2).
  - Last valid window at centre (4,6), coincident with the single frame_done pulse.
  - busy falls after frame_done.
- Random in_valid gaps (~30% idle) → same 24 windows, same coordinate sequence; buf_write count = 48.
- out_ready low for 5 cycles mid-row 3 → in_ready=0, buf_write=0, no counter movement; resumes with no lost or duplicated windows.
- rst asserted at pixel 30, then a new start → outputs cleared immediately; the new frame's first win_valid again follows its pixel 18 with centre (1,1).
- start pulsed during STREAM → err_start=1, frame unaffected; the next start from IDLE clears err_start.
- Boundary check: in every row, win_valid is never raised for col 0 or 1 pixels, and never raised for rows 0 or 1.
